// File: rtl/mem_stream_loader.sv
// Packs a host byte stream MSB-first into memory words and writes them to a
// single-port RAM at sequential addresses from 0, with sticky done/overflow flags.
module mem_stream_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH         = 250
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic [ADDRESS_WIDTH-1:0] word_count,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int BPW = DATA_WIDTH / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CW-1:0]            LAST_BYTE = CW'(BPW - 1);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] DEPTH_CNT = ADDRESS_WIDTH'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   word;
  logic [DATA_WIDTH-1:0]   word_shift;
  logic [DATA_WIDTH-1:0]   word_packed;
  logic [CW-1:0]           byte_cnt;
  logic [CW-1:0]           pad;
  logic                    word_last;
  logic                    accept;
  logic                    word_end;
  logic                    go;

  assign in_ready = (state == LOAD);
  assign busy     = (state == LOAD) || (state == WRITE);
  assign done     = (state == DONE);
  assign wr_en    = (state == WRITE);
  assign wr_data  = wr_en ? word : '0;

  assign accept   = in_valid && in_ready;
  assign go       = start && ((state == IDLE) || (state == DONE));
  assign word_end = (byte_cnt == LAST_BYTE) || in_last;

  // A word closed early by in_last is shifted up so received bytes sit in the MSBs.
  always_comb begin
    word_shift  = (word << 8) | DATA_WIDTH'(in_data);
    pad         = LAST_BYTE - byte_cnt;
    word_packed = word_shift << {pad, 3'b000};
  end

  // NOTE: state registers use non-blocking assignments and an async reset that
  // takes effect without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (accept && word_end) state_nxt = WRITE;
      WRITE:   state_nxt = (word_last || wr_addr == LAST_ADDR) ? DONE : LOAD;
      DONE:    if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word       <= '0;
      byte_cnt   <= '0;
      word_last  <= 1'b0;
      wr_addr    <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else if (go) begin
      word       <= '0;
      byte_cnt   <= '0;
      word_last  <= 1'b0;
      wr_addr    <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            word      <= word_end ? word_packed : word_shift;
            byte_cnt  <= word_end ? '0 : byte_cnt + 1'b1;
            word_last <= in_last;
          end
        end
        WRITE: begin
          word_count <= (word_count == DEPTH_CNT) ? word_count : word_count + 1'b1;
          // The last address is written before overflow is declared; the address never wraps.
          if (!word_last) begin
            if (wr_addr == LAST_ADDR) overflow <= 1'b1;
            else                      wr_addr  <= wr_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
